// File: rtl/wb_regfile_receiver.sv
// ---------------------------------------------------------------------------
// wb_regfile_receiver
//
// Purpose:
//   Clocked receiving end of the writeback stage's two-phase (toggle)
//   bundled-data handshake. Every level change on req_toggle is one write
//   request. The request commits data_in to one of 16 architectural registers
//   and, optionally, cpsr_in to the CPSR. The block then answers with one
//   toggle on ack_toggle. It also serves two registered read ports.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on req_toggle (legal range 2..4)
//   CPSR_RESET   CPSR value after reset
//
// Configuration macro:
//   WB_BYPASS_EN  when defined, a read of the register that is being written
//                 in the WRITE state returns the new data. The read latency
//                 stays at 1 cycle.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_toggle           two-phase write request (asynchronous to clk)
//   data_in, addr_in     bundled result data and destination index
//   cpsr_in, cpsr_we     bundled CPSR value and its commit enable
//   ack_toggle           two-phase acknowledge, one toggle per commit
//   rd_addr_a/b          read port indices
//   rd_data_a/b          registered read data (1-cycle latency)
//   cpsr_out             current CPSR
//   busy                 servicing a request or holding a pending one
//   proto_err            sticky: a request arrived while one was pending
// ---------------------------------------------------------------------------
module wb_regfile_receiver #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CPSR_RESET  = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_toggle,
  input  logic [31:0] data_in,
  input  logic [3:0]  addr_in,
  input  logic [31:0] cpsr_in,
  input  logic        cpsr_we,
  output logic        ack_toggle,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic [31:0] cpsr_out,
  output logic        busy,
  output logic        proto_err
);

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_q;
  logic                   pending_q, pending_d;
  logic                   proto_err_q, proto_err_d;
  logic                   ack_q;
  logic [31:0]            hold_data_q;
  logic [3:0]             hold_addr_q;
  logic [31:0]            hold_cpsr_q;
  logic                   hold_we_q;
  logic [31:0]            regs_q [16];
  logic [31:0]            cpsr_q;
  logic [31:0]            rd_a_q, rd_a_d;
  logic [31:0]            rd_b_q, rd_b_d;

  logic                   req_edge;
  logic                   capture;
  logic                   commit;
  logic                   ack_flip;

  // A change in either direction on the synchronized request is one request.
  assign req_edge = sync_q[SYNC_STAGES-1] ^ ref_q;

  // Next-state logic and the FSM action strobes.
  // NOTE: every always_comb output gets a default first, so that no path leaves
  // a signal unassigned and a latch is inferred.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    proto_err_d = proto_err_q;
    capture     = 1'b0;
    commit      = 1'b0;
    ack_flip    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_edge || pending_q) begin
          capture   = 1'b1;
          state_d   = WRITE;
          // A new edge together with an old pending request serves one of
          // them now and keeps the other queued.
          pending_d = req_edge && pending_q;
        end
      end
      WRITE: begin
        commit  = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        ack_flip = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // There is room for one request in the queue. A further request while the
    // queue is full is dropped and flagged.
    if (state_q != IDLE && req_edge) begin
      if (!pending_q) pending_d   = 1'b1;
      else            proto_err_d = 1'b1;
    end
  end

  // Read ports. With bypass enabled, a read of the register being written
  // returns the held data.
  always_comb begin
    rd_a_d = regs_q[rd_addr_a];
    rd_b_d = regs_q[rd_addr_b];
    if (BYPASS && state_q == WRITE) begin
      if (rd_addr_a == hold_addr_q) rd_a_d = hold_data_q;
      if (rd_addr_b == hold_addr_q) rd_b_d = hold_data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge and the block order does
  // not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      ref_q       <= 1'b0;
      pending_q   <= 1'b0;
      proto_err_q <= 1'b0;
      ack_q       <= 1'b0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      hold_cpsr_q <= '0;
      hold_we_q   <= 1'b0;
      cpsr_q      <= CPSR_RESET;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      // NOTE: the register file is cleared by reset, because software reads
      // these registers as 0 after reset. This stops it from mapping to a RAM
      // macro, which is acceptable for 16 entries.
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], req_toggle};
      ref_q       <= sync_q[SYNC_STAGES-1];
      pending_q   <= pending_d;
      proto_err_q <= proto_err_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;

      if (capture) begin
        hold_data_q <= data_in;
        hold_addr_q <= addr_in;
        hold_cpsr_q <= cpsr_in;
        hold_we_q   <= cpsr_we;
      end
      if (commit) begin
        regs_q[hold_addr_q] <= hold_data_q;
        if (hold_we_q) cpsr_q <= hold_cpsr_q;
      end
      if (ack_flip) ack_q <= ~ack_q;
    end
  end

  assign ack_toggle = ack_q;
  assign rd_data_a  = rd_a_q;
  assign rd_data_b  = rd_b_q;
  assign cpsr_out   = cpsr_q;
  assign busy       = (state_q != IDLE) || pending_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_wb_regfile_receiver.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile_receiver
//
// Self-checking bench for wb_regfile_receiver. The bench drives table vectors
// and a 16-entry handshaked fill through a request/ack scoreboard. It also
// runs hand-written sequences for the following cases:
//   - read-during-write bypass
//   - protocol violation
//   - reset during a write
// ---------------------------------------------------------------------------
module tb_wb_regfile_receiver;

  localparam int          SYNC = 2;
  localparam logic [31:0] CPSR_RST = 32'h0000_00D3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_toggle;
  logic [31:0] data_in;
  logic [3:0]  addr_in;
  logic [31:0] cpsr_in;
  logic        cpsr_we;
  logic        ack_toggle;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] cpsr_out;
  logic        busy;
  logic        proto_err;

  wb_regfile_receiver #(.SYNC_STAGES(SYNC), .CPSR_RESET(CPSR_RST)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_toggle (req_toggle),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .cpsr_in    (cpsr_in),
    .cpsr_we    (cpsr_we),
    .ack_toggle (ack_toggle),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .cpsr_out   (cpsr_out),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  addr;
    logic [31:0] cpsr;
    logic        we;
    logic [31:0] exp_rd;
    logic [31:0] exp_cpsr;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] cpsr;
  } exp_t;

  vec_t vecs [4];
  exp_t sb_q [$];

  int   total = 0;
  int   bad   = 0;
  int   ack_changes;
  logic ack_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle, sampled on the falling edge. Counts ack toggles on the way.
  task automatic tick();
    @(negedge clk);
    if (ack_toggle !== ack_last) ack_changes++;
    ack_last = ack_toggle;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req_toggle = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Compliant requester: drive the bundle, toggle, and wait for the ack.
  // The expected result goes on the scoreboard when the request is driven.
  // It is compared when the ack toggle arrives.
  task automatic do_write(input logic [31:0] d, input logic [3:0] a,
                          input logic [31:0] c, input logic we,
                          input logic [31:0] exp_rd, input logic [31:0] exp_cpsr);
    logic ack_prev;
    int   cyc;
    exp_t e;
    sb_q.push_back('{a, exp_rd, exp_cpsr});
    data_in    = d;
    addr_in    = a;
    cpsr_in    = c;
    cpsr_we    = we;
    ack_prev   = ack_toggle;
    req_toggle = ~req_toggle;
    cyc = 0;
    while (ack_toggle === ack_prev && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ack_latency", 32'(cyc), 32'(SYNC + 3));
    e = sb_q.pop_front();
    rd_addr_a = e.addr;
    rd_addr_b = e.addr;
    tick();
    check("rd_a", rd_data_a, e.data);
    check("rd_b", rd_data_b, e.data);
    check("cpsr", cpsr_out, e.cpsr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_changes = 0;
    ack_last    = 1'b0;
    reset       = 1'b1;
    req_toggle  = 1'b0;
    data_in     = '0;
    addr_in     = '0;
    cpsr_in     = '0;
    cpsr_we     = 1'b0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;

    vecs[0] = '{32'hDEAD_BEEF, 4'd5,  32'h0000_0000, 1'b0, 32'hDEAD_BEEF, CPSR_RST};
    vecs[1] = '{32'h1234_5678, 4'd14, 32'h6000_001F, 1'b1, 32'h1234_5678, 32'h6000_001F};
    vecs[2] = '{32'hCAFE_F00D, 4'd15, 32'hFFFF_FFFF, 1'b0, 32'hCAFE_F00D, 32'h6000_001F};
    vecs[3] = '{32'h0000_0001, 4'd0,  32'h0000_00D3, 1'b1, 32'h0000_0001, 32'h0000_00D3};

    // Reset state.
    apply_reset();
    check("rst_rd_a", rd_data_a, 32'h0);
    check("rst_rd_b", rd_data_b, 32'h0);
    check("rst_cpsr", cpsr_out, CPSR_RST);
    check("rst_ack", 32'(ack_toggle), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_perr", 32'(proto_err), 32'h0);

    // Table vectors: rising toggle, then falling toggle with a CPSR write, ...
    for (int i = 0; i < 4; i++)
      do_write(vecs[i].data, vecs[i].addr, vecs[i].cpsr, vecs[i].we,
               vecs[i].exp_rd, vecs[i].exp_cpsr);

    // Handshaked fill of all 16 registers.
    ack_changes = 0;
    ack_last    = ack_toggle;
    for (int i = 0; i < 16; i++)
      do_write(32'h100 + i, 4'(i), 32'h0, 1'b0, 32'h100 + i, 32'h0000_00D3);
    check("fill_acks", 32'(ack_changes), 32'd16);
    check("fill_perr", 32'(proto_err), 32'h0);

    // Read while addr 3 is written. The old value is 0x103 from the fill.
    rd_addr_a  = 4'd3;
    data_in    = 32'hA5A5_A5A5;
    addr_in    = 4'd3;
    cpsr_we    = 1'b0;
    req_toggle = ~req_toggle;
    repeat (SYNC + 2) tick();
`ifdef WB_BYPASS_EN
    check("bypass_rd", rd_data_a, 32'hA5A5_A5A5);
`else
    check("bypass_rd", rd_data_a, 32'h0000_0103);
`endif
    tick();
    check("after_write_rd", rd_data_a, 32'hA5A5_A5A5);
    tick();

    // Protocol violation: three toggles one cycle apart.
    ack_changes = 0;
    ack_last    = ack_toggle;
    data_in     = 32'h1111_1111;
    addr_in     = 4'd1;
    req_toggle  = ~req_toggle;
    tick();
    req_toggle  = ~req_toggle;
    tick();
    req_toggle  = ~req_toggle;
    // Hold the first bundle until it is captured, then present the second.
    repeat (SYNC - 1) tick();
    data_in = 32'h2222_2222;
    addr_in = 4'd2;
    repeat (15) tick();
    check("perr_acks", 32'(ack_changes), 32'd2);
    check("perr_flag", 32'(proto_err), 32'h1);
    check("perr_busy", 32'(busy), 32'h0);
    rd_addr_a = 4'd1;
    rd_addr_b = 4'd2;
    tick();
    check("perr_reg1", rd_data_a, 32'h1111_1111);
    check("perr_reg2", rd_data_b, 32'h2222_2222);

    // Reset while in WRITE.
    apply_reset();
    check("abort_perr_cleared", 32'(proto_err), 32'h0);
    rd_addr_a  = 4'd7;
    data_in    = 32'h7777_7777;
    addr_in    = 4'd7;
    cpsr_in    = 32'h6000_0010;
    cpsr_we    = 1'b1;
    req_toggle = 1'b1;
    repeat (SYNC + 1) tick();
    check("abort_busy_in_write", 32'(busy), 32'h1);
    apply_reset();
    tick();
    tick();
    check("abort_reg", rd_data_a, 32'h0);
    check("abort_ack", 32'(ack_toggle), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_cpsr", cpsr_out, CPSR_RST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_receiver.md
Name: wb_regfile_receiver

Overview:
- Clocked receiving end of the writeback stage's two-phase (toggle) bundled-data handshake.
- Detects each request toggle, commits the 32-bit result to one of 16 architectural registers and optionally updates the CPSR.
- Returns a toggle acknowledge that the writeback stage waits on as its ready input.
- Also serves two registered read ports to the decode/operand-fetch stage.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on req_toggle; legal range 2..4.
- CPSR_RESET, 32'h0000_00D3, CPSR value after reset (SVC mode, IRQ/FIQ masked).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset
- req_toggle  in  1  two-phase request; every level change is one write request
- data_in  in  32  result data; bundled, stable from toggle until matching ack toggle
- addr_in  in  4  destination register index
- cpsr_in  in  32  new CPSR value; bundled
- cpsr_we  in  1  1 = commit cpsr_in with this request; bundled
- ack_toggle  out  1  two-phase acknowledge; toggles once per committed request
- rd_addr_a  in  4  read port A index
- rd_addr_b  in  4  read port B index
- rd_data_a  out  32  registered read data A
- rd_data_b  out  32  registered read data B
- cpsr_out  out  32  current CPSR
- busy  out  1  1 while a request is being serviced (state != IDLE) or one is pending
- proto_err  out  1  sticky; set when a request arrives while one is already pending

Behaviour:
- Reset is synchronous and active-high. The requester also restarts its trigger at 0.
- Reset values:
  - all 16 registers, rd_data_a, rd_data_b: 0
  - cpsr_out: CPSR_RESET
  - ack_toggle, busy, proto_err: 0
  - synchronizer flops and edge-reference flop: 0
  - pending: 0
  - state: IDLE
- Request detection:
  - req_toggle passes through SYNC_STAGES flops.
  - edge = sync_out XOR ref, and ref <= sync_out every cycle.
  - One edge equals exactly one request, regardless of direction (0->1 or 1->0).
- FSM:
  - IDLE: if edge or pending, capture data_in/addr_in/cpsr_in/cpsr_we into holding registers, clear pending, go to WRITE.
  - WRITE: regs[addr] <= data; if cpsr_we, cpsr_out <= cpsr; go to ACK.
  - ACK: ack_toggle <= ~ack_toggle; go to IDLE.
- Latency:
  - From toggle arrival to synchronized edge: SYNC_STAGES cycles.
  - Register write: 2 cycles after edge.
  - ack_toggle change: 3 cycles after edge.
  - Throughput: 1 request per 3 cycles plus synchronizer delay.
- Edge detected outside IDLE:
  - If pending = 0, set pending; it is served on the next IDLE cycle.
  - If pending = 1, set proto_err (sticky until reset). The request is dropped and no extra ack is produced.
  - The compliant writeback stage never toggles again before its ack, so pending is normally never used.
- Simultaneous edge and pending in IDLE: serve the request, then leave pending set for the second one. No error is raised.
- All 16 registers are plain storage, with no special handling for register 15.
- Reads:
  - rd_data_x <= regs[rd_addr_x] on every clock; 1-cycle latency.
  - Both ports may read the same address.
- Read during a WRITE-state write to the same address: see Optional Feature.
- Reset mid-operation (WRITE or ACK):
  - The write is abandoned; no register or CPSR update occurs.
  - ack_toggle stays 0 and any pending request is discarded.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: in WRITE, a read port whose rd_addr equals the held addr captures the held data, so the new value is visible with the same 1-cycle latency.
- Undefined: such a read returns the old register contents. The new value is visible from the following cycle.

Test Plan:
- Reset check: assert reset for 2 cycles -> all rd_data 0, cpsr_out 0x000000D3, ack_toggle 0, busy 0, proto_err 0.
- Single write: data 0xDEADBEEF, addr 5, cpsr_we 0, toggle req 0->1 -> regs[5] = 0xDEADBEEF after SYNC_STAGES+2 cycles; ack_toggle 0->1 one cycle later; CPSR unchanged; reading addr 5 returns 0xDEADBEEF.
- Falling-toggle write with CPSR: data 0x12345678, addr 14, cpsr 0x6000001F, cpsr_we 1, req 1->0 -> regs[14] = 0x12345678, cpsr_out 0x6000001F, ack_toggle 1->0.
- Back-to-back handshaked writes: 16 writes, value 0x100+i to addr i, each issued on the previous ack -> 16 acks total; each port A/B readback equals 0x100+i; proto_err 0.
- Protocol violation: three toggles 1 cycle apart -> first and second write committed, third dropped, proto_err 1, exactly 2 ack toggles.
- Bypass and reset abort:
  - Read addr 3 while writing 0xA5A5A5A5 to addr 3: 0xA5A5A5A5 with WB_BYPASS_EN, old value without it.
  - Reset asserted in WRITE: target register unchanged (0), ack_toggle 0.
